// File: rtl/speck_round_engine.sv
// Iterative SPECK encrypt/decrypt engine: one round per clock, subkeys fetched
// by index from an external combinational store, start/busy/done framing.
module speck_round_engine #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ALPHA      = 7,
  parameter int unsigned BETA       = 2,
  parameter int unsigned ROUNDS     = 22,
  parameter int unsigned RIDX_W     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [2*WORD_WIDTH-1:0]   block_in,
  output logic [RIDX_W-1:0]         round_idx,
  input  logic [WORD_WIDTH-1:0]     subkey,
  output logic                      busy,
  output logic                      done,
  output logic [2*WORD_WIDTH-1:0]   block_out,
  output logic [1:0]                state_response
);

  localparam int unsigned W = WORD_WIDTH;
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [RIDX_W-1:0] ctr;
  logic [W-1:0]      x_q;
  logic [W-1:0]      y_q;
  logic              mode_q;

  logic [W-1:0]      enc_x_c;
  logic [W-1:0]      enc_y_c;
  logic [W-1:0]      dec_x_c;
  logic [W-1:0]      dec_y_c;
  logic              last_round_c;

  // Rotates by a constant, built from a doubled word so no shift-width mixing occurs.
  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
    logic [2*W-1:0] d;
    d = {v, v} >> s;
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
    logic [2*W-1:0] d;
    d = {v, v} << s;
    return d[2*W-1:W];
  endfunction

  // Forward and inverse round datapaths; the latched mode picks one.
  always_comb begin
    enc_x_c = (ror(x_q, ALPHA) + y_q) ^ subkey;
    enc_y_c = rol(y_q, BETA) ^ enc_x_c;
    dec_y_c = ror(x_q ^ y_q, BETA);
    dec_x_c = rol((x_q ^ subkey) - dec_y_c, ALPHA);
  end

  assign last_round_c = mode_q ? (ctr == '0) : (ctr == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctr       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 1'b0;
      block_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q    <= block_in[W-1:0];
            y_q    <= block_in[2*W-1:W];
            mode_q <= mode;
            ctr    <= mode ? LAST_IDX : '0;
            state  <= ST_ROUND;
            busy   <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (mode_q) begin
            x_q <= dec_x_c;
            y_q <= dec_y_c;
          end else begin
            x_q <= enc_x_c;
            y_q <= enc_y_c;
          end
          // Counter stays on the final index so it never wraps past the range.
          if (last_round_c) begin
            state <= ST_DONE;
          end else if (mode_q) begin
            ctr <= ctr - RIDX_W'(1);
          end else begin
            ctr <= ctr + RIDX_W'(1);
          end
        end
        ST_DONE: begin
          block_out <= {y_q, x_q};
          done      <= 1'b1;
          state     <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign round_idx      = (state == ST_ROUND) ? ctr : '0;
  assign state_response = state;

endmodule

// File: tb/tb_speck_round_engine.sv
// Scoreboard bench for speck_round_engine: SPECK32/64 vectors, handshake,
// mid-operation reset, random round trips, plus a single-round instance.
module tb_speck_round_engine;

  localparam int unsigned W      = 16;
  localparam int unsigned ROUNDS = 22;
  localparam int unsigned RIDX_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start, mode;
  logic [2*W-1:0]    block_in, block_out;
  logic [RIDX_W-1:0] round_idx;
  logic [W-1:0]      subkey;
  logic              busy, done;
  logic [1:0]        state_response;

  logic              start1, mode1;
  logic [2*W-1:0]    block_in1, block_out1;
  logic [0:0]        round_idx1;
  logic [W-1:0]      subkey1;
  logic              busy1, done1;
  logic [1:0]        state_response1;

  logic [W-1:0] rk [32];
  assign subkey  = rk[round_idx];
  assign subkey1 = 16'h0000;

  speck_round_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .block_in(block_in),
    .round_idx(round_idx), .subkey(subkey), .busy(busy), .done(done),
    .block_out(block_out), .state_response(state_response)
  );

  speck_round_engine #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .block_in(block_in1),
    .round_idx(round_idx1), .subkey(subkey1), .busy(busy1), .done(done1),
    .block_out(block_out1), .state_response(state_response1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] blk;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    logic [31:0] d;
    d = {v, v} >> s;
    return d[15:0];
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    logic [31:0] d;
    d = {v, v} << s;
    return d[31:16];
  endfunction

  // Key word order {l2, l1, l0, k0}.
  task automatic set_key(input logic [63:0] key);
    logic [15:0] l [0:24];
    logic [15:0] k;
    k    = key[15:0];
    l[0] = key[31:16];
    l[1] = key[47:32];
    l[2] = key[63:48];
    rk[0] = k;
    for (int i = 0; i < ROUNDS - 1; i++) begin
      l[i+3] = (k + ror16(l[i], 7)) ^ 16'(i);
      k      = rol16(k, 2) ^ l[i+3];
      rk[i+1] = k;
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [31:0] pt);
    logic [15:0] x, y;
    x = pt[15:0];
    y = pt[31:16];
    for (int i = 0; i < ROUNDS; i++) begin
      x = (ror16(x, 7) + y) ^ rk[i];
      y = rol16(y, 2) ^ x;
    end
    return {y, x};
  endfunction

  // Monitors: pop the oldest expectation whenever an instance reports done.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q0.size() == 0) begin
        check("dut done with empty scoreboard", 64'(q0.size()), 64'd1);
      end else begin
        e0 = q0.pop_front();
        check("dut block_out", 64'(block_out), 64'(e0.blk));
        check("dut done cycle", 64'(cyc), 64'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        check("dut1 done with empty scoreboard", 64'(q1.size()), 64'd1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 block_out", 64'(block_out1), 64'(e1.blk));
        check("dut1 done cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  // Call just after a falling edge; leaves start low one cycle later.
  task automatic issue0(input logic m, input logic [31:0] blk, input logic [31:0] expv);
    start    = 1'b1;
    mode     = m;
    block_in = blk;
    q0.push_back('{blk: expv, cyc: cyc + 24});
    @(negedge clk);
    start    = 1'b0;
    mode     = 1'b0;
    block_in = '0;
  endtask

  task automatic wait_done0(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pt, ct;
    bit seen;
    start = 0; mode = 0; block_in = '0;
    start1 = 0; mode1 = 0; block_in1 = '0;
    for (int i = 0; i < 32; i++) rk[i] = '0;

    // Reset held for three cycles, then released with start low.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset block_out", 64'(block_out), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset round_idx", 64'(round_idx), 64'd0);
    check("reset state_response", 64'(state_response), 64'd0);
    check("reset dut1 block_out", 64'(block_out1), 64'd0);

    // Single-round instance, zero subkey.
    start1 = 1'b1;
    block_in1 = 32'h0000_0001;
    q1.push_back('{blk: 32'h0200_0200, cyc: cyc + 3});
    @(negedge clk);
    start1 = 1'b0;
    block_in1 = '0;
    check("dut1 busy in round", 64'(busy1), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done1) begin seen = 1'b1; break; end
    end
    check("dut1 done seen", 64'(seen), 64'd1);

    // SPECK32/64 published vector.
    set_key(64'h1918_1110_0908_0100);
    @(negedge clk);
    issue0(1'b0, 32'h694c_6574, 32'h42f2_a868);
    check("enc state_response round", 64'(state_response), 64'd1);
    check("enc busy", 64'(busy), 64'd1);
    wait_done0("enc vector");

    // Decrypt with the round index walking down.
    @(negedge clk);
    issue0(1'b1, 32'h42f2_a868, 32'h694c_6574);
    for (int i = 0; i < 22; i++) begin
      check("dec round_idx", 64'(round_idx), 64'(21 - i));
      if (i < 21) @(negedge clk);
    end
    wait_done0("dec vector");

    // Start during ROUND ignored; start in the done cycle accepted.
    @(negedge clk);
    issue0(1'b0, 32'h694c_6574, 32'h42f2_a868);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 1'b1; block_in = 32'hdead_beef;
    @(negedge clk);
    start = 1'b0; mode = 1'b0; block_in = '0;
    wait_done0("handshake first");
    check("done-cycle busy", 64'(busy), 64'd0);
    check("done-cycle state_response", 64'(state_response), 64'd0);
    issue0(1'b1, 32'h42f2_a868, 32'h694c_6574);
    wait_done0("handshake back-to-back");

    // Reset mid-operation at round 10.
    @(negedge clk);
    issue0(1'b0, 32'h0123_4567, model_enc(32'h0123_4567));
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q0.delete();
    check("abort block_out", 64'(block_out), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort round_idx", 64'(round_idx), 64'd0);
    check("abort state_response", 64'(state_response), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue0(1'b0, 32'h694c_6574, 32'h42f2_a868);
    wait_done0("after abort");

    // Random keys and blocks: encrypt against the model, decrypt back to plaintext.
    for (int n = 0; n < 20; n++) begin
      set_key({$urandom(), $urandom()});
      pt = $urandom();
      ct = model_enc(pt);
      @(negedge clk);
      issue0(1'b0, pt, ct);
      wait_done0("random enc");
      @(negedge clk);
      issue0(1'b1, ct, pt);
      wait_done0("random dec");
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(q0.size()), 64'd0);
    check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speck_round_engine.md
# speck_round_engine

Parametrised iterative SPECK block-cipher engine: it performs the full ROUNDS-round encryption or decryption of one 2·WORD_WIDTH-bit block, one round per clock. It sits between the key-schedule/subkey store and the cipher top level and replaces the single-round, multi-cycle round function. Mode is selectable per block. Subkeys are fetched by index from an external combinational store, and a start/busy/done handshake frames each block.

## Interface
- WORD_WIDTH, 16, word size W; block is 2W bits.
- ALPHA, 7, right-rotate amount of x; legal range 1..W-1.
- BETA, 2, left-rotate amount of y; legal range 1..W-1.
- ROUNDS, 22, round count; legal range ≥1.
- RIDX_W, $clog2(ROUNDS) (min 1), round-index width.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; latched with start.
- block_in  in  2W  input block; x = [W-1:0], y = [2W-1:W]; latched with start.
- round_idx  out  RIDX_W  subkey index requested this cycle.
- subkey  in  W  subkey for round_idx; must be valid in the same cycle (combinational lookup).
- busy  out  1  high in LOAD-free states ROUND and DONE.
- done  out  1  one-cycle pulse when block_out is updated.
- block_out  out  2W  result; same x/y packing; held until the next completion.
- state_response  out  2  debug state encoding; may be left unconnected.

## Operation
- States: IDLE=0, ROUND=1, DONE=2.
- IDLE, start=1: latch x, y and mode; load the round counter with 0 (encrypt) or ROUNDS-1 (decrypt); go to ROUND.
- IDLE, start=0: no change.
- ROUND, encrypt: x ← (ROR(x,ALPHA) + y) ^ subkey; y ← ROL(y,BETA) ^ x_new. Counter increments.
- ROUND, decrypt: y ← ROR(x ^ y, BETA); x ← ROL((x ^ subkey) − y_new, ALPHA). Counter decrements.
- All arithmetic is modulo 2^W. Rotates are true rotates, not shifts.
- ROUND exits to DONE after the round that uses the last index: ROUNDS-1 for encrypt, 0 for decrypt.
- DONE: block_out ← {y,x}; done=1; go to IDLE.
- round_idx = counter in ROUND; 0 otherwise.
- busy = (state != IDLE).
- start is ignored while busy. mode and block_in are don't-care outside the start cycle.
- Reset values: state IDLE, counter 0, x/y 0, block_out 0, done 0, busy 0, round_idx 0, state_response 0.
- Reset asserted mid-operation aborts the block immediately. No done is produced, and block_out returns to 0.

## Timing
- Start sampled at edge E0. Rounds execute at edges E1..E_ROUNDS. At edge E_ROUNDS+1, block_out and done update.
- done is high from E_ROUNDS+1 to E_ROUNDS+2.
- Latency from start edge to done edge: ROUNDS+1 cycles.
- Back-to-back operation: state is IDLE while done is high, so a start in that cycle is accepted. Throughput is one block per ROUNDS+2 cycles.
- ROUNDS=1: a single ROUND cycle, then DONE.
- subkey is sampled at the same edge that applies the round. The external store has zero-cycle latency relative to round_idx.
- Outputs are registered, except round_idx, which is a direct decode of the counter and state.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0, state_response=0; start held 0 keeps IDLE.
- Single-round encrypt (ROUNDS=1, W=16): block_in=32'h0000_0001, subkey=0 -> block_out=32'h0200_0200, done one cycle after the round.
- SPECK32/64 vector: subkeys come from the bench model of key 1918 1110 0908 0100.
  - Encrypt block_in=32'h694c_6574 -> block_out=32'h42f2_a868, done at start+23 edges.
  - Decrypt of 32'h42f2_a868 -> 32'h694c_6574; round_idx sequence 21..0.
- Handshake: pulse start during ROUND with different data -> ignored, result unchanged. Assert start in the done cycle -> second block accepted, its done exactly 24 cycles later.
- Reset mid-operation: drop rst_n at round 10 -> outputs 0 asynchronously, no done. A fresh start afterwards yields the correct ciphertext.
- Random regression (W=16/24/32/48/64 with standard ALPHA/BETA): 1000 random blocks and keys, encrypt then decrypt -> matches the model and round-trips to plaintext.
